// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the serial TX framer: state encoding,
// default start sequence and counter sizing.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEQ,
    ST_DATA,
    ST_PARITY,
    ST_DONE,
    ST_GAP
  } tx_state_t;

  localparam logic [5:0] DEFAULT_START_SEQ = 6'b01_1111;

  // Bits needed to hold the largest count the framer ever loads.
  function automatic int cnt_width(input int seq_w, input int data_w, input int gap);
    int m;
    m = seq_w;
    if (data_w > m) m = data_w;
    if (gap > m) m = gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/tx_shift_reg.sv
// Parallel-in/serial-out payload register, MSB first. With TX_PARITY_EN it
// also accumulates even parity over the bits shifted out since the last load.
module tx_shift_reg #(
  parameter int DATA_W = 55
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              msb
`ifdef TX_PARITY_EN
  ,
  output logic              parity
`endif
);

  logic [DATA_W-1:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= din;
    end else if (shift) begin
      sr_q <= sr_q << 1;
    end
  end

  assign msb = sr_q[DATA_W-1];

`ifdef TX_PARITY_EN
  // Parity of every bit that has left the register, so it is complete once
  // the last data bit has been emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity <= 1'b0;
    end else if (load) begin
      parity <= 1'b0;
    end else if (shift) begin
      parity <= parity ^ sr_q[DATA_W-1];
    end
  end
`endif

endmodule

// File: rtl/serial_tx_framer.sv
// Serial frame transmitter: start sequence, MSB-first payload, optional even
// parity (define TX_PARITY_EN), done pulse and programmable inter-frame gap.
module serial_tx_framer
  import serial_tx_pkg::*;
#(
  parameter int               DATA_W     = 55,
  parameter int               SEQ_W      = 6,
  parameter logic [SEQ_W-1:0] START_SEQ  = DEFAULT_START_SEQ,
  parameter int               GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              start,
  output logic              ready,
  output logic              s_data,
  output logic              done
);

  // Handshake: start is taken only in a cycle where ready=1; at that edge
  // tx_data is captured and ready drops until the frame and gap are over.

  localparam int CW = cnt_width(SEQ_W, DATA_W, GAP_CYCLES);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] SEQ_LEN  = CW'(SEQ_W);
  localparam logic [CW-1:0] DATA_LEN = CW'(DATA_W);
  localparam logic [CW-1:0] GAP_LEN  = CW'(GAP_CYCLES);

  tx_state_t        state_q, state_nx;
  logic [CW-1:0]    cnt_q, cnt_nx;
  logic [SEQ_W-1:0] seq_q, seq_nx;
  logic             load, shift, msb, s_data_nx;
`ifdef TX_PARITY_EN
  logic             parity;
`endif

  tx_shift_reg #(.DATA_W(DATA_W)) u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .shift (shift),
    .din   (tx_data),
    .msb   (msb)
`ifdef TX_PARITY_EN
    ,
    .parity(parity)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      seq_q   <= '0;
      ready   <= 1'b0;
      done    <= 1'b0;
      s_data  <= 1'b0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      seq_q   <= seq_nx;
      ready   <= (state_nx == ST_IDLE);
      done    <= (state_nx == ST_DONE);
      s_data  <= s_data_nx;
    end
  end

  // Outputs are registered, so each branch chooses the line value for the
  // state being entered; the payload shifts as each bit is launched.
  always_comb begin
    state_nx  = state_q;
    cnt_nx    = cnt_q;
    seq_nx    = seq_q;
    load      = 1'b0;
    shift     = 1'b0;
    s_data_nx = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ready && start) begin
          state_nx  = ST_SEQ;
          cnt_nx    = SEQ_LEN;
          load      = 1'b1;
          s_data_nx = START_SEQ[SEQ_W-1];
          seq_nx    = START_SEQ << 1;
        end
      end
      ST_SEQ: begin
        if (cnt_q == ONE) begin
          state_nx  = ST_DATA;
          cnt_nx    = DATA_LEN;
          shift     = 1'b1;
          s_data_nx = msb;
        end else begin
          cnt_nx    = cnt_q - ONE;
          s_data_nx = seq_q[SEQ_W-1];
          seq_nx    = seq_q << 1;
        end
      end
      ST_DATA: begin
        if (cnt_q == ONE) begin
          cnt_nx = '0;
`ifdef TX_PARITY_EN
          state_nx  = ST_PARITY;
          s_data_nx = parity;
`else
          state_nx  = ST_DONE;
`endif
        end else begin
          cnt_nx    = cnt_q - ONE;
          shift     = 1'b1;
          s_data_nx = msb;
        end
      end
`ifdef TX_PARITY_EN
      ST_PARITY: state_nx = ST_DONE;
`endif
      ST_DONE: begin
        if (GAP_CYCLES > 0) begin
          state_nx = ST_GAP;
          cnt_nx   = GAP_LEN;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (cnt_q == ONE) state_nx = ST_IDLE;
        else              cnt_nx   = cnt_q - ONE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_tx_framer.sv
// Directed bench for serial_tx_framer: a default 55-bit instance and an
// 8-bit instance with a 3-cycle gap, both driven from one clock.
module tb_serial_tx_framer;

`ifdef TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int LA = 6 + 55 + PAR;
  localparam int LB = 6 + 8 + PAR;

  logic        clk = 1'b0;
  logic        rst_a_n, rst_b_n;
  logic [54:0] tx_data_a;
  logic [7:0]  tx_data_b;
  logic        start_a, start_b;
  logic        ready_a, ready_b, s_data_a, s_data_b, done_a, done_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_tx_framer dut_a (
    .clk(clk), .rst_n(rst_a_n), .tx_data(tx_data_a), .start(start_a),
    .ready(ready_a), .s_data(s_data_a), .done(done_a)
  );

  serial_tx_framer #(.DATA_W(8), .GAP_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .tx_data(tx_data_b), .start(start_b),
    .ready(ready_b), .s_data(s_data_b), .done(done_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready_a(input string name);
    int n = 0;
    while (ready_a !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (ready_a !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s wait_ready_a: ready=%b after %0d cycles, required 1", name, ready_a, n);
    end
  endtask

  task automatic wait_ready_b(input string name);
    int n = 0;
    while (ready_b !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (ready_b !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s wait_ready_b: ready=%b after %0d cycles, required 1", name, ready_b, n);
    end
  endtask

  task automatic run_frame_a(input logic [54:0] d, input logic exp_par, input string name);
    logic       exp_q[$];
    logic [5:0] seq = 6'b011111;
    logic       e;
    int         bad_idx = -1;
    logic       bad_val = 1'b0;
    logic       bad_exp = 1'b0;
    int         stray = 0;
    wait_ready_a(name);
    for (int i = 5; i >= 0; i--) exp_q.push_back(seq[i]);
    for (int i = 54; i >= 0; i--) exp_q.push_back(d[i]);
    if (PAR == 1) exp_q.push_back(exp_par);
    tx_data_a = d;
    start_a   = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < LA; i++) begin
      e = exp_q.pop_front();
      if (s_data_a !== e && bad_idx < 0) begin
        bad_idx = i; bad_val = s_data_a; bad_exp = e;
      end
      if (done_a !== 1'b0 || ready_a !== 1'b0) stray++;
      tick();
    end
    checks++;
    if (bad_idx >= 0) begin
      errors++;
      $display("FAIL %s serial: bit %0d got %b, required %b", name, bad_idx, bad_val, bad_exp);
    end
    checks++;
    if (done_a !== 1'b1 || s_data_a !== 1'b0 || ready_a !== 1'b0 || stray != 0) begin
      errors++;
      $display("FAIL %s done_cycle: done=%b s_data=%b ready=%b stray=%0d, required 1/0/0/0",
               name, done_a, s_data_a, ready_a, stray);
    end
    tick();
    checks++;
    if (ready_a !== 1'b1 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_after_done: ready=%b done=%b, required 1/0", name, ready_a, done_a);
    end
  endtask

  task automatic run_frame_b(input logic [7:0] d, input logic exp_par, input int poke_at,
                             input string name);
    logic       exp_q[$];
    logic [5:0] seq = 6'b011111;
    logic       e;
    int         bad_idx = -1;
    logic       bad_val = 1'b0;
    logic       bad_exp = 1'b0;
    int         stray = 0;
    int         gap_bad = 0;
    wait_ready_b(name);
    for (int i = 5; i >= 0; i--) exp_q.push_back(seq[i]);
    for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
    if (PAR == 1) exp_q.push_back(exp_par);
    tx_data_b = d;
    start_b   = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < LB; i++) begin
      if (i == poke_at) begin
        start_b   = 1'b1;
        tx_data_b = 8'hFF;
      end else if (i == poke_at + 1) begin
        start_b = 1'b0;
      end
      e = exp_q.pop_front();
      if (s_data_b !== e && bad_idx < 0) begin
        bad_idx = i; bad_val = s_data_b; bad_exp = e;
      end
      if (done_b !== 1'b0 || ready_b !== 1'b0) stray++;
      tick();
    end
    start_b = 1'b0;
    checks++;
    if (bad_idx >= 0) begin
      errors++;
      $display("FAIL %s serial: bit %0d got %b, required %b", name, bad_idx, bad_val, bad_exp);
    end
    checks++;
    if (done_b !== 1'b1 || s_data_b !== 1'b0 || ready_b !== 1'b0 || stray != 0) begin
      errors++;
      $display("FAIL %s done_cycle: done=%b s_data=%b ready=%b stray=%0d, required 1/0/0/0",
               name, done_b, s_data_b, ready_b, stray);
    end
    tick();
    for (int g = 0; g < 3; g++) begin
      if (ready_b !== 1'b0 || s_data_b !== 1'b0 || done_b !== 1'b0) gap_bad++;
      tick();
    end
    checks++;
    if (gap_bad != 0 || ready_b !== 1'b1) begin
      errors++;
      $display("FAIL %s gap: bad_gap_cycles=%0d ready_after=%b, required 0 and 1", name, gap_bad, ready_b);
    end
  endtask

  task automatic test_reset;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    tx_data_a = '0; tx_data_b = '0;
    repeat (3) tick();
    checks++;
    if ({ready_a, done_a, s_data_a} !== 3'b000) begin
      errors++;
      $display("FAIL reset_a: ready/done/s_data=%b, required 000", {ready_a, done_a, s_data_a});
    end
    checks++;
    if ({ready_b, done_b, s_data_b} !== 3'b000) begin
      errors++;
      $display("FAIL reset_b: ready/done/s_data=%b, required 000", {ready_b, done_b, s_data_b});
    end
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    tick();
    checks++;
    if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: ready_a=%b ready_b=%b, required 1/1", ready_a, ready_b);
    end
  endtask

  task automatic test_default_frame;
    run_frame_a(55'h1, 1'b1, "default_frame");
  endtask

  task automatic test_parity_frame;
    run_frame_b(8'hA7, 1'b1, -10, "frame_a7");
  endtask

  task automatic test_back_to_back;
    int acc[3] = '{0, 0, 0};
    int n_acc = 0;
    int k = 0;
    int ready_hi = 0;
    int done_cnt = 0;
    logic prev_ready;
    wait_ready_b("back_to_back");
    tx_data_b  = 8'h3C;
    start_b    = 1'b1;
    prev_ready = ready_b;
    while (n_acc < 3 && k < 200) begin
      tick();
      k++;
      if (prev_ready === 1'b1) begin
        acc[n_acc] = k;
        n_acc++;
      end
      if (n_acc == 1 && ready_b === 1'b1) ready_hi++;
      if (n_acc == 1 && done_b === 1'b1) done_cnt++;
      prev_ready = ready_b;
    end
    start_b = 1'b0;
    checks++;
    if (n_acc != 3 || acc[1] - acc[0] != LB + 5) begin
      errors++;
      $display("FAIL b2b_period_1: accepts=%0d spacing=%0d, required 3 and %0d", n_acc, acc[1] - acc[0], LB + 5);
    end
    checks++;
    if (acc[2] - acc[1] != LB + 5) begin
      errors++;
      $display("FAIL b2b_period_2: spacing=%0d, required %0d", acc[2] - acc[1], LB + 5);
    end
    checks++;
    if (ready_hi != 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL b2b_ready_done: ready_high_cycles=%0d done_pulses=%0d, required 1/1", ready_hi, done_cnt);
    end
  endtask

  task automatic test_ignore_midframe;
    int busy = 0;
    run_frame_b(8'h5A, 1'b0, 9, "frame_5a_poked");
    for (int i = 0; i < 5; i++) begin
      if (ready_b !== 1'b1 || s_data_b !== 1'b0 || done_b !== 1'b0) busy++;
      tick();
    end
    checks++;
    if (busy != 0) begin
      errors++;
      $display("FAIL no_second_frame: non-idle cycles=%0d, required 0", busy);
    end
  endtask

  task automatic test_reset_midframe;
    int done_seen = 0;
    wait_ready_a("reset_midframe");
    tx_data_a = 55'h7F_FFFF_FFFF_FFFF;
    start_a   = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (26) tick();
    checks++;
    if (s_data_a !== 1'b1 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL pre_abort: s_data=%b done=%b, required 1/0", s_data_a, done_a);
    end
    rst_a_n = 1'b0;
    #1;
    checks++;
    if ({ready_a, done_a, s_data_a} !== 3'b000) begin
      errors++;
      $display("FAIL abort_immediate: ready/done/s_data=%b, required 000", {ready_a, done_a, s_data_a});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done_a !== 1'b0) done_seen++;
    end
    rst_a_n = 1'b1;
    if (done_a !== 1'b0) done_seen++;
    tick();
    checks++;
    if (ready_a !== 1'b1 || done_a !== 1'b0 || done_seen != 0) begin
      errors++;
      $display("FAIL abort_release: ready=%b done=%b done_seen=%0d, required 1/0/0", ready_a, done_a, done_seen);
    end
    run_frame_a(55'h2A_5A5A_0F0F_3C3C, 1'b1, "frame_after_abort");
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_parity_frame();
    test_back_to_back();
    test_ignore_midframe();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
